// File: rtl/dense_to_coo_encoder.sv
// Dense 8x8 FP8 raster stream to 32-entry COO table encoder (IDLE/SCAN/DONE).
// Optional macro COO_FLUSH_SUBNORMAL_EN: also drop subnormals (exponent field zero).
module dense_to_coo_encoder #(
  parameter int N       = 8,
  parameter int MAX_NNZ = 32,
  parameter int DW      = 8,
  parameter int IW      = $clog2(N),
  parameter int CW      = $clog2(MAX_NNZ + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DW-1:0]                 in_data,
  output logic [MAX_NNZ-1:0][DW-1:0]    coo_data,
  output logic [MAX_NNZ-1:0][IW-1:0]    coo_row,
  output logic [MAX_NNZ-1:0][IW-1:0]    coo_col,
  output logic [MAX_NNZ-1:0]            coo_valid,
  output logic [CW-1:0]                 nnz,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] row_ctr_reg, col_ctr_reg;
  logic [CW-1:0] nnz_reg;
  logic          overflow_reg;

  logic start_clear, accept, is_zero, table_full, last_col, last_elem;

  // Sign bit is ignored so that -0 is dropped along with +0.
`ifdef COO_FLUSH_SUBNORMAL_EN
  assign is_zero = (in_data[6:3] == 4'd0);
`else
  assign is_zero = (in_data[DW-2:0] == '0);
`endif

  assign start_clear = (state_reg == IDLE) && start;
  assign accept      = (state_reg == SCAN) && in_valid;
  assign table_full  = (nnz_reg == CW'(MAX_NNZ));
  assign last_col    = (col_ctr_reg == IW'(N - 1));
  assign last_elem   = last_col && (row_ctr_reg == IW'(N - 1));

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = SCAN;
      SCAN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && last_elem) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      row_ctr_reg  <= '0;
      col_ctr_reg  <= '0;
      nnz_reg      <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_clear) begin
        row_ctr_reg  <= '0;
        col_ctr_reg  <= '0;
        nnz_reg      <= '0;
        overflow_reg <= 1'b0;
      end else if (accept) begin
        if (last_col) begin
          col_ctr_reg <= '0;
          row_ctr_reg <= row_ctr_reg + IW'(1);
        end else begin
          col_ctr_reg <= col_ctr_reg + IW'(1);
        end
        if (!is_zero) begin
          if (table_full) overflow_reg <= 1'b1;
          else            nnz_reg      <= nnz_reg + CW'(1);
        end
      end
    end
  end

  assign nnz      = nnz_reg;
  assign overflow = overflow_reg;

  // One register slot per table entry; the slot addressed by nnz captures the beat.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_NNZ; gi++) begin : g_entry
      logic          wr_en;
      logic [DW-1:0] data_reg;
      logic [IW-1:0] row_reg, col_reg;
      logic          valid_reg;

      assign wr_en = accept && !is_zero && !table_full && (nnz_reg == CW'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_reg  <= '0;
          row_reg   <= '0;
          col_reg   <= '0;
          valid_reg <= 1'b0;
        end else if (start_clear) begin
          valid_reg <= 1'b0;
        end else if (wr_en) begin
          data_reg  <= in_data;
          row_reg   <= row_ctr_reg;
          col_reg   <= col_ctr_reg;
          valid_reg <= 1'b1;
        end
      end

      assign coo_data[gi]  = data_reg;
      assign coo_row[gi]   = row_reg;
      assign coo_col[gi]   = col_reg;
      assign coo_valid[gi] = valid_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dense_to_coo_encoder.sv
// Table-driven bench for dense_to_coo_encoder with a queue scoreboard of expected COO entries.
module tb_dense_to_coo_encoder;

  localparam int N = 8, MAX_NNZ = 32, DW = 8, IW = 3, CW = 6;

  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, busy, done, overflow;
  logic [DW-1:0] in_data;
  logic [MAX_NNZ-1:0][DW-1:0] coo_data;
  logic [MAX_NNZ-1:0][IW-1:0] coo_row, coo_col;
  logic [MAX_NNZ-1:0] coo_valid;
  logic [CW-1:0] nnz;

  dense_to_coo_encoder dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .coo_data(coo_data), .coo_row(coo_row), .coo_col(coo_col),
    .coo_valid(coo_valid), .nnz(nnz), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [2:0] r;
    logic [2:0] c;
  } ent_t;

  typedef struct {
    int kind;
    bit gaps;
    int exp_nnz;
    bit exp_ovf;
    int exp_done;
  } vec_t;

  ent_t sb[$];
  vec_t vecs[5];
  int errors = 0;
  int checks = 0;
  int last_cyc, last_nnz;
  bit last_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] elem(input int kind, input int idx);
    int r, c;
    r = idx / 8;
    c = idx % 8;
    case (kind)
      0: return (r == c) ? 8'h38 : 8'h00;
      1: return idx[0] ? 8'h80 : 8'h00;
      2: return 8'(idx + 1);
      default: return (r == 2 && c == 5) ? 8'h01 : 8'h00;
    endcase
  endfunction

  function automatic bit model_zero(input logic [7:0] e);
`ifdef COO_FLUSH_SUBNORMAL_EN
    return e[6:3] == 4'd0;
`else
    return e[6:0] == 7'd0;
`endif
  endfunction

  // Starts a matrix and feeds up to stop_after beats; the start cycle is cycle 1.
  task automatic run_matrix(input int kind, input bit gaps, input int stop_after);
    int idx = 0, j = 0, cyc = 1, mnz = 0;
    bit movf = 1'b0;
    logic [7:0] e;
    sb.delete();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 2;
    chk("busy_after_start", busy, 1);
    while (idx < stop_after && j < 400) begin
      e = elem(kind, idx);
      in_valid = gaps ? j[0] : 1'b1;
      in_data = e;
      chk("in_ready_scan", in_ready, 1);
      chk("done_low_scan", done, 0);
      @(posedge clk); #1;
      cyc++;
      if (in_valid) begin
        if (!model_zero(e)) begin
          if (mnz < MAX_NNZ) begin
            sb.push_back('{e, 3'(idx / 8), 3'(idx % 8)});
            mnz++;
          end else begin
            movf = 1'b1;
          end
        end
        idx++;
      end
      j++;
      chk("nnz_track", nnz, mnz);
      chk("ovf_track", overflow, movf);
    end
    in_valid = 1'b0;
    if (j >= 400) begin
      errors++;
      $display("FAIL scan_timeout: got %0d beats expected %0d", idx, stop_after);
    end
    last_cyc = cyc;
    last_nnz = mnz;
    last_ovf = movf;
  endtask

  // Called in the cycle right after the final beat: expects DONE there.
  task automatic verify(input vec_t v);
    int cnt;
    ent_t e;
    logic [63:0] mask;
    chk("done_pulse", done, 1);
    chk("done_cycle", last_cyc, v.exp_done);
    chk("in_ready_done", in_ready, 0);
    chk("nnz_final", nnz, v.exp_nnz);
    chk("model_nnz", last_nnz, v.exp_nnz);
    chk("overflow_final", overflow, v.exp_ovf);
    cnt = sb.size();
    for (int i = 0; i < cnt; i++) begin
      e = sb.pop_front();
      chk($sformatf("data[%0d]", i), coo_data[i], e.d);
      chk($sformatf("row[%0d]", i), coo_row[i], e.r);
      chk($sformatf("col[%0d]", i), coo_col[i], e.c);
    end
    mask = (64'd1 << cnt) - 64'd1;
    chk("coo_valid", coo_valid, mask[31:0]);
  endtask

  initial begin
    vecs[0] = '{0, 1'b0, 8, 1'b0, 66};
    vecs[1] = '{1, 1'b0, 0, 1'b0, 66};
    vecs[2] = '{2, 1'b0, 32, 1'b1, 66};
    vecs[3] = '{0, 1'b1, 8, 1'b0, 130};
`ifdef COO_FLUSH_SUBNORMAL_EN
    vecs[4] = '{3, 1'b0, 0, 1'b0, 66};
`else
    vecs[4] = '{3, 1'b0, 1, 1'b0, 66};
`endif

    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nnz", nnz, 0);
    chk("rst_valid", coo_valid, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_data", |coo_data, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_in_ready", in_ready, 0);

    for (int v = 0; v < 5; v++) begin
      run_matrix(vecs[v].kind, vecs[v].gaps, 64);
      verify(vecs[v]);
      $display("vec %0d kind=%0d gaps=%0d nnz=%0d ovf=%0d done_cycle=%0d",
               v, vecs[v].kind, vecs[v].gaps, nnz, overflow, last_cyc);
      @(posedge clk); #1;
      chk("done_one_cycle", done, 0);
      chk("idle_after_done", in_ready, 0);
      chk("nnz_hold", nnz, vecs[v].exp_nnz);
    end

    // start presented during DONE must be ignored
    run_matrix(0, 1'b0, 64);
    chk("done_pulse_b", done, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", in_ready, 0);
    chk("start_in_done_busy", busy, 0);
    chk("start_in_done_nnz", nnz, 8);
    @(posedge clk); #1;
    chk("still_idle", in_ready, 0);
    $display("seq start_during_done in_ready=%0d nnz=%0d", in_ready, nnz);

    // asynchronous reset after 20 beats
    run_matrix(0, 1'b0, 20);
    chk("pre_reset_nnz", nnz, 3);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_nnz", nnz, 0);
    chk("mid_rst_valid", coo_valid, 0);
    chk("mid_rst_data", |coo_data, 0);
    chk("mid_rst_rowcol", (|coo_row) | (|coo_col), 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_overflow", overflow, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) rst = 1'b1;
      @(posedge clk); #1;
      chk("no_done_after_rst", done, 0);
      chk("idle_after_rst", in_ready, 0);
    end
    $display("seq reset_mid_scan nnz=%0d valid=%0h", nnz, coo_valid);
    run_matrix(0, 1'b0, 64);
    verify(vecs[0]);
    $display("seq diag_after_reset nnz=%0d done_cycle=%0d", nnz, last_cyc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
